// File: rtl/mem_addr_sel_ctrl.sv
// mem_addr_sel_ctrl: selects one of NSRC address sources on a request and checks it.
// It holds the address on the memory port until mem_ack, or until the wait times out.
module mem_addr_sel_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 5,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            size,
  input  logic                  req,
  input  logic                  mem_ack,
  output logic [WIDTH-1:0]      mem_addr,
  output logic                  mem_req,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d, cand;
  logic             req_q, req_d, done_q, done_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             sel_ok, mis;
  always_comb begin
    cand = '0;
    for (int i = 0; i < NSRC; i++)
      if (int'(sel) == i) cand = src_flat[i*WIDTH +: WIDTH];
  end
  assign sel_ok = int'(sel) < NSRC;
  // reserved size 11 checks as a word access
  assign mis = size[1] ? |cand[1:0] : size[0] & cand[0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    req_d   = req_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (!sel_ok || mis) begin
          code_d  = sel_ok ? 2'b10 : 2'b01;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          addr_d  = cand;
          req_d   = 1'b1;
          code_d  = 2'b00;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: if (mem_ack) begin
        req_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        req_d   = 1'b0;
        code_d  = 2'b11;
        err_d   = 1'b1;
        state_d = ERR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_req  = req_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
endmodule
